// File: rtl/mii_tx_framer_pkg.sv
// Shared types and constants for the MII transmit framer and its nibble CRC.
package mii_tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DROP,
        ST_IFG
    } state_t;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;

    // Number of 0x5 nibbles on the wire before the 0xD that closes the SFD.
    localparam int PRE_NIBBLES = 15;

    // FCS nibble k: inverted, bit-reversed crc[31-4k:28-4k].
    function automatic logic [3:0] fcs_nibble(input logic [31:0] crc, input logic [2:0] k);
        logic [31:0] sh;
        sh = crc << {k, 2'b00};
        return ~{sh[28], sh[29], sh[30], sh[31]};
    endfunction

endpackage

// File: rtl/eth_crc32_d4.sv
// Ethernet CRC-32 (poly 0x04C11DB7), MSB-first register, 4 input bits per clock
// taken LSB first (bit-reversed nibble input).
module eth_crc32_d4
    import mii_tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  data_in,
    input  logic        crc_en,
    output logic [31:0] crc_out
);

    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc_out;
        for (int i = 0; i < 4; i++) begin
            if (crc_next[31] ^ data_in[i]) begin
                crc_next = {crc_next[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_next = {crc_next[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_out <= CRC_INIT;
        end else if (crc_en) begin
            crc_out <= crc_next;
        end
    end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD, payload nibbles, zero pad, FCS and
// inter-frame gap from a byte stream; underrun aborts the frame with tx_er.
module mii_tx_framer
    import mii_tx_framer_pkg::*;
#(
    parameter int MIN_BYTES   = 60,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [3:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_BYTES);
    localparam logic [15:0] PRE_LAST = 16'(PRE_NIBBLES - 2);
    localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 1);

    state_t      state, state_nx;
    logic        phase, phase_nx;
    logic [10:0] count, count_nx, count_inc;
    logic [15:0] tick, tick_nx;
    logic [3:0]  txd_nx;
    logic        tx_en_nx, tx_er_nx;
    logic        crc_en, crc_init_q, crc_rst;
    logic [31:0] crc;

    // Handshake: a byte moves when s_valid && s_ready at a rising edge; s_valid
    // must then hold the byte and s_last steady until that edge.
    assign s_ready   = ((state == ST_DATA) && phase) || (state == ST_DROP);
    assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;

    // Outputs are registered decisions of the current cycle, so the wire
    // shows each state's nibble one clock later; IDLE emits the first 0x5.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        count_nx = count;
        tick_nx  = tick;
        txd_nx   = 4'h0;
        tx_en_nx = 1'b0;
        tx_er_nx = 1'b0;
        crc_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    state_nx = ST_PRE;
                    tx_en_nx = 1'b1;
                    txd_nx   = PREAMBLE_NIB;
                    tick_nx  = 16'd1;
                    count_nx = 11'd0;
                    phase_nx = 1'b0;
                end
            end
            ST_PRE: begin
                tx_en_nx = 1'b1;
                txd_nx   = PREAMBLE_NIB;
                tick_nx  = tick + 16'd1;
                if (tick == PRE_LAST) begin
                    state_nx = ST_SFD;
                    tick_nx  = 16'd0;
                end
            end
            ST_SFD: begin
                tx_en_nx = 1'b1;
                if (tick == 16'd0) begin
                    txd_nx  = PREAMBLE_NIB;
                    tick_nx = 16'd1;
                end else begin
                    txd_nx   = SFD_NIB;
                    state_nx = ST_DATA;
                    tick_nx  = 16'd0;
                    phase_nx = 1'b0;
                end
            end
            ST_DATA: begin
                tx_en_nx = 1'b1;
                if (!s_valid) begin
                    tx_er_nx = 1'b1;
                    state_nx = ST_DROP;
                end else begin
                    crc_en   = 1'b1;
                    phase_nx = ~phase;
                    if (!phase) begin
                        txd_nx = s_data[3:0];
                    end else begin
                        txd_nx   = s_data[7:4];
                        count_nx = count_inc;
                        if (s_last) begin
                            tick_nx  = 16'd0;
                            state_nx = (count_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                        end
                    end
                end
            end
            ST_PAD: begin
                tx_en_nx = 1'b1;
                crc_en   = 1'b1;
                phase_nx = ~phase;
                if (phase) begin
                    count_nx = count_inc;
                    if (count_inc >= MIN_CNT) begin
                        state_nx = ST_FCS;
                        tick_nx  = 16'd0;
                    end
                end
            end
            ST_FCS: begin
                tx_en_nx = 1'b1;
                txd_nx   = fcs_nibble(crc, tick[2:0]);
                tick_nx  = tick + 16'd1;
                if (tick == 16'd7) begin
                    state_nx = ST_IFG;
                    tick_nx  = 16'd0;
                end
            end
            ST_DROP: begin
                if (s_valid && s_last) begin
                    state_nx = ST_IFG;
                    tick_nx  = 16'd0;
                end
            end
            ST_IFG: begin
                tick_nx = tick + 16'd1;
                if (tick == IFG_LAST) begin
                    state_nx = ST_IDLE;
                    tick_nx  = 16'd0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= 1'b0;
            count      <= 11'd0;
            tick       <= 16'd0;
            txd        <= 4'h0;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            busy       <= 1'b0;
            crc_init_q <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            count      <= count_nx;
            tick       <= tick_nx;
            txd        <= txd_nx;
            tx_en      <= tx_en_nx;
            tx_er      <= tx_er_nx;
            busy       <= (state_nx != ST_IDLE);
            crc_init_q <= (state_nx == ST_PRE);
        end
    end

    // The CRC is held at its seed for the whole preamble by a glitch-free flop.
    assign crc_rst = rst | crc_init_q;

    eth_crc32_d4 u_crc (
        .clk     (clk),
        .rst     (crc_rst),
        .data_in (txd_nx),
        .crc_en  (crc_en),
        .crc_out (crc)
    );

endmodule
